mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one memory port between instruction fetch (ibus) and the EX-stage LSU (dbus).
//  Grants one requester at a time, drives a registered request to memory and holds ownership until done.
//  A write is done when memory accepts it; a read is done when its rvalid returns.
//  LSU has priority; a starvation counter guarantees fetch progress under back-to-back loads/stores.
// PARAMETERS
//  AW            32  address width
//  DW            32  data width (multiple of 8); strobe width DW/8
//  STARVE_LIMIT  4   consecutive dbus grants with ibus_req pending before ibus forced; legal 1..15
// PORTS
//  clk          in   1      clock; all state on rising edge
//  rst          in   1      reset, asynchronous assert, active-low (0 = reset)
//  ibus_req     in   1      fetch request; held with ibus_addr until ibus_ready
//  ibus_addr    in   AW     fetch address (read only)
//  ibus_ready   out  1      fetch request accepted by memory this cycle
//  ibus_rvalid  out  1      fetch read data valid this cycle
//  ibus_rdata   out  DW     fetch read data (= mem_rdata)
//  dbus_req     in   1      LSU request; held with fields until dbus_ready
//  dbus_we      in   1      1 = write, 0 = read
//  dbus_addr    in   AW     LSU address
//  dbus_wdata   in   DW     LSU write data
//  dbus_wstrb   in   DW/8   LSU byte strobes (writes only)
//  dbus_ready   out  1      LSU request accepted by memory this cycle
//  dbus_rvalid  out  1      LSU read data valid this cycle
//  dbus_rdata   out  DW     LSU read data (= mem_rdata)
//  mem_req      out  1      registered request to memory
//  mem_we / mem_addr / mem_wdata / mem_wstrb  out  1/AW/DW/DW8  registered request fields
//  mem_ready    in   1      memory accepts request when mem_req & mem_ready
//  mem_rvalid   in   1      read response valid (one per accepted read, >=1 cycle after accept)
//  mem_rdata    in   DW     read response data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, owner=none, starve_cnt=0, mem_req=0, mem_we=0, mem_addr/wdata/wstrb=0.
//   ibus/dbus_ready=0 and ibus/dbus_rvalid=0 immediately.
//  States:
//   IDLE  - no owner; arbitrate at the clock edge.
//   REQ   - mem_req=1 with latched fields; wait for mem_ready.
//   RESP  - read accepted; wait for mem_rvalid.
//  Transitions:
//   IDLE->REQ on any req; the winner's fields are latched into mem_* and mem_req rises on the next cycle.
//   REQ->IDLE on mem_ready if the access is a write.
//   REQ->RESP on mem_ready if the access is a read; mem_req drops the cycle after acceptance.
//   RESP->IDLE on mem_rvalid.
//  Arbitration (IDLE only):
//   - Only dbus_req: grant dbus.
//   - Only ibus_req: grant ibus.
//   - Both, starve_cnt < STARVE_LIMIT: grant dbus.
//   - Both, starve_cnt == STARVE_LIMIT: grant ibus.
//  starve_cnt (4 bit):
//   - +1 on a dbus grant while ibus_req=1.
//   - Cleared on an ibus grant or on a dbus grant with ibus_req=0.
//   - Saturates at STARVE_LIMIT, never wraps.
//  Handshake:
//   - owner_ready = mem_req & mem_ready & (owner match); combinational; non-owner ready is 0.
//   - owner_rvalid = mem_rvalid & (state==RESP) & (owner match); rdata is broadcast to both buses.
//   - An ibus grant drives mem_we=0 and mem_wstrb=0.
//   - Requester fields are sampled only at grant; later changes are ignored until done.
//  Latency (zero-wait memory, mem_ready=1):
//   - req->ready is 1 cycle; write costs 2 cycles per access.
//   - Read costs 2 cycles + memory read latency; IDLE always inserts 1 cycle between accesses.
//  Boundaries:
//   - mem_rvalid outside RESP (stray or post-reset) is ignored; no rvalid to either bus.
//   - mem_ready while mem_req=0 is ignored.
//   - A req dropped by a requester before ready violates protocol; the latched access still completes.
//   - Reset mid-REQ/RESP abandons the access; mem_req drops asynchronously.
//   - A reset during RESP leaves the late rvalid ignored.
// TESTING
//  T1 dbus write A=0x100 D=0xDEADBEEF strb=0xF, mem_ready=1 -> mem_req 1 cycle later with those fields; dbus_ready pulses once; IDLE next.
//  T2 ibus read 0x40, memory rvalid 3 cycles after accept, rdata=0x13 -> ibus_rvalid single pulse with 0x13; dbus_rvalid stays 0.
//  T3 ibus_req and dbus_req both held high, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I...
//  T4 mem_ready held 0 for 5 cycles in REQ, then 1 -> mem_* fields stable throughout; exactly one ready pulse to owner.
//  T5 rst=0 asserted in RESP, then released; memory returns rvalid 2 cycles later -> mem_req=0 at once, no bus rvalid, FSM stays IDLE.
//  T6 mem_rvalid pulsed in IDLE with no access -> no ibus/dbus rvalid; next dbus read completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter: shares one registered memory request between
// instruction fetch (ibus) and the LSU (dbus), LSU first with fetch anti-starvation.
module mem_bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ibus_req,
  input  logic [AW-1:0]   ibus_addr,
  output logic            ibus_ready,
  output logic            ibus_rvalid,
  output logic [DW-1:0]   ibus_rdata,
  input  logic            dbus_req,
  input  logic            dbus_we,
  input  logic [AW-1:0]   dbus_addr,
  input  logic [DW-1:0]   dbus_wdata,
  input  logic [DW/8-1:0] dbus_wstrb,
  output logic            dbus_ready,
  output logic            dbus_rvalid,
  output logic [DW-1:0]   dbus_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic       own_i;
  logic       own_d;
  logic [3:0] starve_cnt;
  logic       grant_i;
  logic       grant_d;
  logic       in_resp;

  // fetch wins only when alone or when the LSU has had its quota
  assign grant_i = ibus_req & (~dbus_req | (starve_cnt == LIMIT));
  assign grant_d = dbus_req & ~grant_i;
  assign in_resp = (state == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      own_i      <= 1'b0;
      own_d      <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_i | grant_d) begin
            state   <= REQ;
            mem_req <= 1'b1;
            own_i   <= grant_i;
            own_d   <= grant_d;
          end
          unique case (1'b1)
            grant_i: begin
              mem_we     <= 1'b0;
              mem_addr   <= ibus_addr;
              mem_wdata  <= '0;
              mem_wstrb  <= '0;
              starve_cnt <= '0;
            end
            grant_d: begin
              mem_we    <= dbus_we;
              mem_addr  <= dbus_addr;
              mem_wdata <= dbus_wdata;
              mem_wstrb <= dbus_wstrb;
              if (!ibus_req)
                starve_cnt <= '0;
              else if (starve_cnt < LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
            end
            default: ;
          endcase
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= mem_we ? IDLE : RESP;
          end
        end
        RESP: begin
          if (mem_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ibus_ready  = mem_req & mem_ready & own_i;
  assign dbus_ready  = mem_req & mem_ready & own_d;
  assign ibus_rvalid = mem_rvalid & in_resp & own_i;
  assign dbus_rvalid = mem_rvalid & in_resp & own_d;
  assign ibus_rdata  = mem_rdata;
  assign dbus_rdata  = mem_rdata;

endmodule
